// File: rtl/uart_tx_arbiter.sv
// Four-source UART transmitter: round-robin arbitration, byte capture at
// acceptance, and 8N1 (or 8N2) serialisation on a single idle-high tx line.
module uart_tx_arbiter #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic        tx,
   output logic        busy,
   output logic [1:0]  grant_id,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [1:0]  rr_q, rr_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic [3:0]  req_ready_q, req_ready_d;
   logic [1:0]  grant_id_q, grant_id_d;
   logic        frame_done_q, frame_done_d;

   logic        pick_valid;
   logic [1:0]  pick_id;
   logic [1:0]  scan_idx;
   logic        baud_last;

   // Round-robin pick: first pending requester at or above the RR pointer, mod 4.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = '0;
      scan_idx   = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         scan_idx = rr_q + 2'(k);
         if (!pick_valid && req_valid[scan_idx]) begin
            pick_valid = 1'b1;
            pick_id    = scan_idx;
         end
      end
   end

   // Frame controller: acceptance, bit timing and serial output sequencing.
   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_idx_d    = bit_idx_q;
      shreg_d      = shreg_q;
      rr_d         = rr_q;
      tx_d         = tx_q;
      busy_d       = busy_q;
      req_ready_d  = '0;
      grant_id_d   = grant_id_q;
      frame_done_d = 1'b0;
      baud_last    = (baud_q == BAUD_LAST);

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               shreg_d     = req_data[{pick_id, 3'b000} +: 8];
               req_ready_d = 4'b0001 << pick_id;
               grant_id_d  = pick_id;
               rr_d        = pick_id + 2'd1;
               baud_d      = '0;
               bit_idx_d   = '0;
               tx_d        = 1'b0;
               busy_d      = 1'b1;
               state_d     = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               tx_d      = shreg_q[0];
               state_d   = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  tx_d      = 1'b1;
                  state_d   = STOP;
               end else begin
                  // tx takes the next bit directly so it lines up with the shift.
                  bit_idx_d = bit_idx_q + 3'd1;
                  shreg_d   = shreg_q >> 1;
                  tx_d      = shreg_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_idx_q == STOP_LAST) begin
                  bit_idx_d    = '0;
                  busy_d       = 1'b0;
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state_q      <= IDLE;
         baud_q       <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
         rr_q         <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         req_ready_q  <= '0;
         grant_id_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_idx_q    <= bit_idx_d;
         shreg_q      <= shreg_d;
         rr_q         <= rr_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         req_ready_q  <= req_ready_d;
         grant_id_q   <= grant_id_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLKS_PER_BIT=4 (one-stop and two-stop instances).
module tb_uart_tx_arbiter;

  logic        CLOCK_50;
  logic        RESET_N;
  logic [3:0]  req_valid, req_valid2;
  logic [31:0] req_data, req_data2;
  logic [3:0]  req_ready, req_ready2;
  logic        tx, tx2, busy, busy2, frame_done, frame_done2;
  logic [1:0]  grant_id, grant_id2;

  int vectors     = 0;
  int miscompares = 0;
  int lat;

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
    .tx(tx2), .busy(busy2), .grant_id(grant_id2), .frame_done(frame_done2)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Wait (bounded) for a req_ready pulse and check it belongs to requester id.
  task automatic wait_grant(input logic [1:0] id, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == 4'b0000 && n < 100);
    chk("grant_seen", (req_ready != 4'b0000), 1'b1);
    chk("grant_ready", req_ready, (4'b0001 << id));
    chk("grant_id", grant_id, id);
  endtask

  // Starting at the first start-bit cycle, check 40 cycles of 8N1 framing then frame_done.
  task automatic check_frame(input logic [7:0] b);
    logic       e;
    logic [7:0] t;
    for (int unsigned c = 0; c < 40; c++) begin
      if (c < 4) e = 1'b0;
      else if (c < 36) begin
        t = b >> ((c - 4) / 4);
        e = t[0];
      end else e = 1'b1;
      chk("frame_tx", tx, e);
      chk("frame_busy", busy, 1'b1);
      chk("frame_done_early", frame_done, 1'b0);
      if (c > 0) chk("ready_extra", req_ready, 4'b0000);
      tick();
    end
    chk("done_pulse", frame_done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_tx", tx, 1'b1);
  endtask

  initial begin
    RESET_N    = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_valid2 = '0;
    req_data2  = '0;
    tick();
    tick();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_gid", grant_id, 2'd0);
    chk("rst_tx2", tx2, 1'b1);

    // Single byte from requester 2.
    RESET_N   = 1'b1;
    req_valid = 4'b0100;
    req_data  = 32'h0055_0000;
    wait_grant(2'd2, lat);
    chk("single_lat", lat, 1);
    req_valid = '0;
    check_frame(8'h55);
    tick();
    chk("single_after_done", frame_done, 1'b0);

    // All four valid from reset release: grants 0,1,2,3.
    RESET_N   = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    tick();
    RESET_N = 1'b1;
    wait_grant(2'd0, lat);
    req_valid = 4'b1110;
    check_frame(8'h11);
    wait_grant(2'd1, lat);
    chk("rr_lat1", lat, 1);
    req_valid = 4'b1100;
    check_frame(8'h22);
    wait_grant(2'd2, lat);
    req_valid = 4'b1000;
    check_frame(8'h33);
    wait_grant(2'd3, lat);
    req_valid = 4'b0000;
    check_frame(8'h44);

    // Fairness: 0 and 3 held continuously alternate.
    req_valid = 4'b1001;
    req_data  = 32'h3C00_00C3;
    wait_grant(2'd0, lat);
    check_frame(8'hC3);
    wait_grant(2'd3, lat);
    check_frame(8'h3C);
    wait_grant(2'd0, lat);
    check_frame(8'hC3);
    wait_grant(2'd3, lat);
    req_valid = 4'b0000;
    check_frame(8'h3C);
    tick();
    tick();
    chk("fair_idle_tx", tx, 1'b1);
    chk("fair_idle_busy", busy, 1'b0);

    // Back-to-back from requester 1; data changed after acceptance must not leak in.
    req_valid = 4'b0010;
    req_data  = 32'h0000_A500;
    wait_grant(2'd1, lat);
    req_data = 32'h0000_0F00;
    check_frame(8'hA5);
    wait_grant(2'd1, lat);
    chk("b2b_lat", lat, 1);
    req_valid = 4'b0000;
    check_frame(8'h0F);

    // Reset during data bit 3 of 0xFF; RR pointer returns to 0.
    req_valid = 4'b0100;
    req_data  = 32'h00FF_0000;
    wait_grant(2'd2, lat);
    req_valid = 4'b0000;
    for (int unsigned c = 0; c < 17; c++) tick();
    chk("mid_busy", busy, 1'b1);
    RESET_N   = 1'b0;
    req_valid = 4'b1001;
    req_data  = 32'h9600_005A;
    tick();
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", frame_done, 1'b0);
    chk("abort_ready", req_ready, 4'b0000);
    RESET_N = 1'b1;
    wait_grant(2'd0, lat);
    chk("post_rst_lat", lat, 1);
    req_valid = 4'b1000;
    check_frame(8'h5A);
    wait_grant(2'd3, lat);
    req_valid = 4'b0000;
    check_frame(8'h96);

    // Two stop bits, byte 0x00: 36 low cycles, 8 high, then frame_done.
    req_valid2 = 4'b0001;
    req_data2  = 32'h0000_0000;
    tick();
    chk("sb2_ready", req_ready2, 4'b0001);
    req_valid2 = 4'b0000;
    for (int unsigned c = 0; c < 44; c++) begin
      chk("sb2_tx", tx2, (c < 36) ? 1'b0 : 1'b1);
      chk("sb2_busy", busy2, 1'b1);
      chk("sb2_done_early", frame_done2, 1'b0);
      tick();
    end
    chk("sb2_done", frame_done2, 1'b1);
    chk("sb2_done_busy", busy2, 1'b0);
    chk("sb2_done_tx", tx2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
